// File: rtl/final_3002_pkg.sv
// Shared types and segment constants for the final_3002 stopwatch.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package final_3002_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_P     = 7'h0C;

  // Returns {carry_out, next_digit}; any digit >= 9 wraps so the
  // result always stays in 0..9.
  function automatic logic [4:0] bcd_inc(input bcd_t d);
    if (d >= 4'd9) return {1'b1, 4'd0};
    else           return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/final_3002_seg7_decoder.sv
// BCD to active-low 7-segment decoder with blanking.
// Non-BCD inputs decode to blank.
module seg7_decoder
  import final_3002_pkg::*;
(
  input  bcd_t       i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/final_3002.sv
// Four-digit BCD stopwatch with start/stop button and state display.
// Define FINAL_3002_LZB_EN to blank leading zeros on HEX5..HEX3.
module final_3002
  import final_3002_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX0
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          w_rst;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic          w_press;
  state_e        r_state;
  state_e        w_state_nxt;
  logic [PW-1:0] r_pre;
  logic          w_tick;
  bcd_t          r_dig [4];
  bcd_t          w_dig_nxt [4];
  logic [3:0]    w_blank;

  assign w_rst = KEY[0];

  // Synchronizer flops reset high so a held button is not a press.
  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= KEY[1];
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_press = r_s2 & ~r_s3;

  always_comb begin
    w_state_nxt = r_state;
    if (w_press) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      r_pre <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_pre == PRE_LAST) r_pre <= '0;
      else                   r_pre <= r_pre + PW'(1);
    end
  end

  // Ripple the tick through the digits within one cycle.
  always_comb begin
    logic       carry;
    logic [4:0] inc;
    carry = w_tick;
    inc   = '0;
    for (int i = 0; i < 4; i++) begin
      w_dig_nxt[i] = r_dig[i];
      if (carry) begin
        inc          = bcd_inc(r_dig[i]);
        w_dig_nxt[i] = inc[3:0];
        carry        = inc[4];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_rst) begin
      for (int i = 0; i < 4; i++) r_dig[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) r_dig[i] <= w_dig_nxt[i];
    end
  end

`ifdef FINAL_3002_LZB_EN
  assign w_blank[3] = (r_dig[3] == 4'd0);
  assign w_blank[2] = w_blank[3] && (r_dig[2] == 4'd0);
  assign w_blank[1] = w_blank[2] && (r_dig[1] == 4'd0);
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = 4'b0000;
`endif

  seg7_decoder u_dec3 (
    .i_bcd   (r_dig[3]),
    .i_blank (w_blank[3]),
    .o_seg   (HEX5)
  );

  seg7_decoder u_dec2 (
    .i_bcd   (r_dig[2]),
    .i_blank (w_blank[2]),
    .o_seg   (HEX4)
  );

  seg7_decoder u_dec1 (
    .i_bcd   (r_dig[1]),
    .i_blank (w_blank[1]),
    .o_seg   (HEX3)
  );

  seg7_decoder u_dec0 (
    .i_bcd   (r_dig[0]),
    .i_blank (w_blank[0]),
    .o_seg   (HEX2)
  );

  always_comb begin
    case (r_state)
      ST_IDLE:  HEX0 = SEG_DASH;
      ST_RUN:   HEX0 = SEG_R;
      ST_PAUSE: HEX0 = SEG_P;
      default:  HEX0 = SEG_DASH;
    endcase
  end

endmodule

// File: tb/tb_final_3002.sv
// Randomised self-checking bench for final_3002 (TICK_DIV=4)
// against an arithmetic model of the stopwatch.
module tb_final_3002;

  localparam int TD = 4;

  logic       clk;
  logic [1:0] key;
  logic [6:0] hex5, hex4, hex3, hex2, hex0;

  final_3002 #(.TICK_DIV(TD)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .HEX5     (hex5),
    .HEX4     (hex4),
    .HEX3     (hex3),
    .HEX2     (hex2),
    .HEX0     (hex0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
  endtask

  // ---- behavioural model ----
  // mst: 0 idle, 1 run, 2 pause; mcnt: displayed count as an integer
  int mst = 0;
  int mpre = 0;
  int mcnt = 0;
  bit samp [1:3];
  bit mvalid = 0;

  always @(posedge clk) begin
    bit press, tick;
    if (key[0]) begin
      mst = 0; mpre = 0; mcnt = 0;
      samp[1] = 1; samp[2] = 1; samp[3] = 1;
      mvalid = 1;
    end else begin
      // samp[k] = KEY[1] as seen k edges ago
      press = samp[2] && !samp[3];
      tick  = (mst == 1) && (mpre == TD - 1);
      if (mst == 1) mpre = (mpre + 1) % TD;
      if (tick) mcnt = (mcnt + 1) % 10000;
      if (press) mst = (mst == 1) ? 2 : 1;
      samp[3] = samp[2];
      samp[2] = samp[1];
      samp[1] = key[1];
    end
  end

  function automatic logic [6:0] dseg(input int d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic logic [6:0] eh(input int pos);
    int d;
    int p10;
    p10 = (pos == 3) ? 1000 : (pos == 2) ? 100 : (pos == 1) ? 10 : 1;
    d = (mcnt / p10) % 10;
`ifdef FINAL_3002_LZB_EN
    if (pos > 0 && mcnt < p10) return 7'h7F;
`endif
    return dseg(d);
  endfunction

  function automatic logic [6:0] eh0();
    return (mst == 0) ? 7'h3F : (mst == 1) ? 7'h2F : 7'h0C;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("hex5", hex5, eh(3));
      chk("hex4", hex4, eh(2));
      chk("hex3", hex3, eh(1));
      chk("hex2", hex2, eh(0));
      chk("hex0", hex0, eh0());
    end
  end

  // ---- stimulus ----
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit4(input string name, input logic [6:0] e5,
                      input logic [6:0] e4, input logic [6:0] e3,
                      input logic [6:0] e2);
    chk({name, "_h5"}, hex5, e5);
    chk({name, "_h4"}, hex4, e4);
    chk({name, "_h3"}, hex3, e3);
    chk({name, "_h2"}, hex2, e2);
  endtask

  task automatic press5();
    key[1] = 1'b1;
    cyc(5);
    key[1] = 1'b0;
  endtask

  initial begin
    int r;
    key = 2'b01;
    cyc(3);
    key[0] = 1'b0;
    cyc(1);
`ifdef FINAL_3002_LZB_EN
    lit4("rst", 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
    lit4("rst", 7'h40, 7'h40, 7'h40, 7'h40);
`endif
    chk("rst_h0", hex0, 7'h3F);
    cyc(100);
    chk("idle100_h0", hex0, 7'h3F);
    chk("idle100_h2", hex2, 7'h40);

    // start: RUN visible exactly 3 edges after the rise
    key[1] = 1'b1;
    cyc(2);
    chk("start_e2_h0", hex0, 7'h3F);
    cyc(1);
    chk("start_e3_h0", hex0, 7'h2F);
    cyc(2);
    key[1] = 1'b0;
    cyc(10);
    chk("run12_h2", hex2, 7'h30);
    chk("run11_h2", hex2, dseg(3));

    // pause, hold 50 cycles, resume
    key[1] = 1'b1;
    cyc(3);
    chk("pause_h0", hex0, 7'h0C);
    cyc(2);
    key[1] = 1'b0;
    cyc(50);
    chk("pause50_h0", hex0, 7'h0C);
    press5();
    chk("resume_h0", hex0, 7'h2F);
    cyc(20);

    // run to 9999 then wrap
    for (int i = 0; i < 50000 && mcnt != 9999; i++) cyc(1);
    lit4("c9999", 7'h10, 7'h10, 7'h10, 7'h10);
    for (int i = 0; i < 10 && mcnt != 0; i++) cyc(1);
`ifdef FINAL_3002_LZB_EN
    lit4("wrap", 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
    lit4("wrap", 7'h40, 7'h40, 7'h40, 7'h40);
`endif
    for (int i = 0; i < 400 && mcnt != 42; i++) cyc(1);
`ifdef FINAL_3002_LZB_EN
    lit4("c0042", 7'h7F, 7'h7F, 7'h19, 7'h24);
`else
    lit4("c0042", 7'h40, 7'h40, 7'h19, 7'h24);
`endif

    // reset mid-RUN on the same edge as a press pulse
    key[1] = 1'b1;
    cyc(2);
    key[0] = 1'b1;
    cyc(1);
    key[0] = 1'b0;
    chk("rstrun_h0", hex0, 7'h3F);
    chk("rstrun_h2", hex2, 7'h40);
    chk("rstrun_h3", hex3, eh(1));
    cyc(10);
    chk("held_h0", hex0, 7'h3F);
    key[1] = 1'b0;
    cyc(5);

    // random button activity with occasional resets
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) key[0] = 1'b1;
      else if (r < 50) key[1] = ~key[1];
      cyc($urandom_range(1, 12));
      key[0] = 1'b0;
    end
    key = 2'b00;
    cyc(5);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/final_3002.md
FINAL_3002 -- requirements
Module: final_3002

Interface
REQ-001 Parameter TICK_DIV, default 50000000, SHALL set the clock cycles per count tick (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-003 KEY[0]  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 KEY[1]  input  1  SHALL be the start/stop button, asynchronous, active-high.
REQ-005 HEX5, HEX4, HEX3, HEX2  output  7 each  SHALL drive the thousands, hundreds, tens and units digit, in that order.
REQ-006 HEX0  output  7  SHALL drive the state indicator.
REQ-007 All HEX outputs SHALL be active-low, bit order {g,f,e,d,c,b,a}; no HEX1 port exists.

Function
REQ-008 Digit codes SHALL be: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, blank=0x7F.
REQ-009 KEY[1] SHALL pass through a 2-flop synchronizer plus a third history flop; press = s2 & ~s3, a one-cycle pulse.
REQ-010 A press pulse SHALL take effect on the same clock edge, i.e. 3 cycles after KEY[1] rises before a CLOCK_50 edge.
REQ-011 The FSM SHALL have three states: IDLE, RUN and PAUSE.
REQ-012 FSM transitions SHALL be: IDLE->RUN on press, RUN->PAUSE on press, PAUSE->RUN on press, otherwise hold; only reset returns to IDLE.
REQ-013 HEX0 SHALL show '-' (0x3F) in IDLE, 'r' (0x2F) in RUN and 'P' (0x0C) in PAUSE.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 only while in RUN, emit a tick when it wraps to 0, and hold its value in IDLE and PAUSE.
REQ-015 On each tick, a 4-digit BCD counter SHALL increment by 1; carries ripple within the same cycle; 9999 SHALL wrap to 0000.
REQ-016 Each BCD digit SHALL stay in 0..9 at all times.
REQ-017 A press and a tick on the same cycle SHALL both take effect: the count increments and the state changes.
REQ-018 HEX outputs SHALL be combinational decodes of the registered counter and state, valid in the cycle after the update.

Reset
REQ-019 While KEY[0]=1 at a clock edge, the block SHALL load: state=IDLE, prescaler=0, counter=0000, synchronizer flops=1.
REQ-020 Reset SHALL take priority over a press and over a tick on the same edge; reset mid-RUN SHALL discard the count.
REQ-021 Because the synchronizer flops reset to 1, KEY[1] held high through reset release SHALL NOT produce a press.
REQ-022 After reset, HEX5..HEX2 SHALL read 0x40 (or 0x7F,0x7F,0x7F,0x40 with blanking enabled) and HEX0 SHALL read 0x3F.

Configuration
REQ-023 With macro FINAL_3002_LZB_EN defined, leading zeros on HEX5..HEX3 SHALL be blanked (0x7F); HEX2 SHALL always show a digit.
REQ-024 Without FINAL_3002_LZB_EN, all four digits SHALL always be displayed.

Structure
REQ-025 Package final_3002_pkg SHALL hold the state enum, the segment constants (digits 0..9, blank, '-', 'r', 'P') and the BCD digit typedef.
REQ-026 Sub-module seg7_decoder (4-bit BCD in, 7-bit active-low out, blank input) SHALL be instantiated four times.
REQ-027 The whole block SHALL be implemented in about 120-400 lines of RTL.

Verification (TICK_DIV=4)
REQ-028 Reset then release with KEY[1]=0 -> HEX5..HEX2=0x40 (both macro settings as applicable) and HEX0=0x3F; stable for 100 cycles.
REQ-029 Press KEY[1] for 5 cycles -> HEX0=0x2F exactly 3 cycles after the rise; the count reaches 0003 after 12 further cycles.
REQ-030 Second press -> HEX0=0x0C and the count frozen for 50 cycles; third press -> counting resumes from the frozen value with no tick lost or gained.
REQ-031 Preload by running to 9999, then one more tick -> 0000 in a single cycle with no illegal BCD digit.
REQ-032 Assert KEY[0] mid-RUN together with a press -> next edge gives IDLE and 0000; KEY[1] held high through release produces no start.
REQ-033 With FINAL_3002_LZB_EN and count 0042 -> HEX5=0x7F, HEX4=0x7F, HEX3=0x19, HEX2=0x24.
